// File: rtl/axi4l_regfile.sv
// AXI4-Lite slave register file with independent write/read channel FSMs.
// Define AXI4L_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4l_regfile #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NUM_REGS   = 16
) (
   input  logic                           axi4l_aclk,
   input  logic                           axi4l_rst,
   input  logic [ADDR_WIDTH-1:0]          awaddr,
   input  logic                           awvalid,
   output logic                           awready,
   input  logic [DATA_WIDTH-1:0]          wdata,
   input  logic [DATA_WIDTH/8-1:0]        wstrb,
   input  logic                           wvalid,
   output logic                           wready,
   output logic [1:0]                     bresp,
   output logic                           bvalid,
   input  logic                           bready,
   input  logic [ADDR_WIDTH-1:0]          araddr,
   input  logic                           arvalid,
   output logic                           arready,
   output logic [DATA_WIDTH-1:0]          rdata,
   output logic [1:0]                     rresp,
   output logic                           rvalid,
   input  logic                           rready,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
   output logic [NUM_REGS-1:0]            reg_wr_stb
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned OFF_W  = $clog2(STRB_W);
   localparam int unsigned IDX_W  = $clog2(NUM_REGS);
   localparam int unsigned HI_LSB = OFF_W + IDX_W;
   localparam logic [1:0]  RESP_OKAY = 2'b00;
`ifdef AXI4L_REGFILE_SLVERR_EN
   localparam logic [1:0]  OOR_RESP = 2'b10;
`else
   localparam logic [1:0]  OOR_RESP = RESP_OKAY;
`endif

   typedef enum logic [1:0] {WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP} wr_state_e;
   typedef enum logic       {RD_IDLE, RD_RESP} rd_state_e;

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[OFF_W +: IDX_W];
   endfunction

   function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
      return |(a >> HI_LSB);
   endfunction

   wr_state_e               wr_state_q, wr_state_d;
   rd_state_e               rd_state_q, rd_state_d;
   logic                    rdy_en_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_W-1:0]       wstrb_q, wstrb_d;
   logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]     wr_stb_q, wr_stb_d;
   logic [1:0]              bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [1:0]              rresp_q, rresp_d;

   logic                    aw_hs_c, w_hs_c, ar_hs_c, commit_c, wr_oor_c;
   logic [ADDR_WIDTH-1:0]   wr_addr_c;
   logic [DATA_WIDTH-1:0]   wr_data_c;
   logic [STRB_W-1:0]       wr_strb_c;
   logic [IDX_W-1:0]        wr_idx_c;

   assign aw_hs_c = awvalid && awready;
   assign w_hs_c  = wvalid && wready;
   assign ar_hs_c = arvalid && arready;

   // Readies stay low until the first edge that samples reset deasserted.
   always_ff @(posedge axi4l_aclk) begin
      if (axi4l_rst) rdy_en_q <= 1'b0;
      else           rdy_en_q <= 1'b1;
   end

   // Write FSM: state register
   always_ff @(posedge axi4l_aclk) begin
      if (axi4l_rst) wr_state_q <= WR_IDLE;
      else           wr_state_q <= wr_state_d;
   end

   // Write FSM: next state
   always_comb begin
      wr_state_d = wr_state_q;
      case (wr_state_q)
         WR_IDLE: begin
            if (aw_hs_c && w_hs_c) wr_state_d = WR_RESP;
            else if (aw_hs_c)      wr_state_d = WR_HAVE_ADDR;
            else if (w_hs_c)       wr_state_d = WR_HAVE_DATA;
         end
         WR_HAVE_ADDR: if (w_hs_c)  wr_state_d = WR_RESP;
         WR_HAVE_DATA: if (aw_hs_c) wr_state_d = WR_RESP;
         WR_RESP:      if (bready)  wr_state_d = WR_IDLE;
         default:                   wr_state_d = WR_IDLE;
      endcase
   end

   // Write FSM: outputs decoded from state
   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      bvalid  = 1'b0;
      case (wr_state_q)
         WR_IDLE: begin
            awready = rdy_en_q;
            wready  = rdy_en_q;
         end
         WR_HAVE_ADDR: wready  = rdy_en_q;
         WR_HAVE_DATA: awready = rdy_en_q;
         WR_RESP:      bvalid  = 1'b1;
         default: ;
      endcase
   end

   // Read FSM: state register
   always_ff @(posedge axi4l_aclk) begin
      if (axi4l_rst) rd_state_q <= RD_IDLE;
      else           rd_state_q <= rd_state_d;
   end

   // Read FSM: next state
   always_comb begin
      rd_state_d = rd_state_q;
      case (rd_state_q)
         RD_IDLE: if (ar_hs_c) rd_state_d = RD_RESP;
         RD_RESP: if (rready)  rd_state_d = RD_IDLE;
         default:              rd_state_d = RD_IDLE;
      endcase
   end

   // Read FSM: outputs decoded from state
   always_comb begin
      arready = 1'b0;
      rvalid  = 1'b0;
      case (rd_state_q)
         RD_IDLE: arready = rdy_en_q;
         RD_RESP: rvalid  = 1'b1;
         default: ;
      endcase
   end

   // Commit uses whichever half was captured earlier plus the half arriving now.
   assign commit_c  = (wr_state_q != WR_RESP) && (wr_state_d == WR_RESP);
   assign wr_addr_c = (wr_state_q == WR_HAVE_ADDR) ? awaddr_q : awaddr;
   assign wr_data_c = (wr_state_q == WR_HAVE_DATA) ? wdata_q  : wdata;
   assign wr_strb_c = (wr_state_q == WR_HAVE_DATA) ? wstrb_q  : wstrb;
   assign wr_oor_c  = addr_oor(wr_addr_c);
   assign wr_idx_c  = addr_idx(wr_addr_c);

   // Datapath next-state: captures, byte-lane writes, responses
   always_comb begin
      awaddr_d = awaddr_q;
      wdata_d  = wdata_q;
      wstrb_d  = wstrb_q;
      regs_d   = regs_q;
      wr_stb_d = '0;
      bresp_d  = bresp_q;
      rdata_d  = rdata_q;
      rresp_d  = rresp_q;
      if (aw_hs_c) awaddr_d = awaddr;
      if (w_hs_c) begin
         wdata_d = wdata;
         wstrb_d = wstrb;
      end
      if (commit_c) begin
         bresp_d = wr_oor_c ? OOR_RESP : RESP_OKAY;
         if (!wr_oor_c) begin
            for (int unsigned k = 0; k < STRB_W; k++) begin
               if (wr_strb_c[k]) regs_d[wr_idx_c][k*8 +: 8] = wr_data_c[k*8 +: 8];
            end
            wr_stb_d[wr_idx_c] = 1'b1;
         end
      end
      // Reads sample pre-edge contents, so a same-edge write is not visible.
      if (ar_hs_c) begin
         if (addr_oor(araddr)) begin
            rdata_d = '0;
            rresp_d = OOR_RESP;
         end else begin
            rdata_d = regs_q[addr_idx(araddr)];
            rresp_d = RESP_OKAY;
         end
      end
   end

   always_ff @(posedge axi4l_aclk) begin
      if (axi4l_rst) begin
         awaddr_q <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
         wr_stb_q <= '0;
         bresp_q  <= RESP_OKAY;
         rdata_q  <= '0;
         rresp_q  <= RESP_OKAY;
      end else begin
         awaddr_q <= awaddr_d;
         wdata_q  <= wdata_d;
         wstrb_q  <= wstrb_d;
         regs_q   <= regs_d;
         wr_stb_q <= wr_stb_d;
         bresp_q  <= bresp_d;
         rdata_q  <= rdata_d;
         rresp_q  <= rresp_d;
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
      assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
   end

   assign reg_wr_stb = wr_stb_q;
   assign bresp      = bresp_q;
   assign rdata      = rdata_q;
   assign rresp      = rresp_q;

endmodule

// File: doc/axi4l_regfile.md
AXI4L_REGFILE -- requirements
Module: axi4l_regfile

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width (32 or 64).
REQ-003 SHALL have parameter NUM_REGS, default 16, register count (power of 2, 2..256).
REQ-004 SHALL have ports: axi4l_aclk  in  1  clock; axi4l_rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have slave ports awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready, at the widths of the axi4l_if slave modport.
REQ-006 SHALL have port reg_q  out  NUM_REGS*DATA_WIDTH  current register contents, register i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port reg_wr_stb  out  NUM_REGS  one-cycle pulse on the cycle after register i is written.

Function
REQ-008 SHALL decode index = addr[$clog2(DATA_WIDTH/8) +: $clog2(NUM_REGS)]; byte-offset bits ignored.
REQ-009 SHALL treat an address as out-of-range when any bit above the index field is set.
REQ-010 Write FSM states: WR_IDLE, WR_HAVE_ADDR, WR_HAVE_DATA, WR_RESP.
REQ-011 awready high only in WR_IDLE or WR_HAVE_DATA; wready high only in WR_IDLE or WR_HAVE_ADDR.
REQ-012 WR_IDLE: AW only -> WR_HAVE_ADDR; W only -> WR_HAVE_DATA; both same cycle -> WR_RESP.
REQ-013 WR_HAVE_ADDR + W handshake -> WR_RESP; WR_HAVE_DATA + AW handshake -> WR_RESP.
REQ-014 Register updated on the clock edge entering WR_RESP, byte lane k written only when wstrb[k]=1.
REQ-015 bvalid high exactly while in WR_RESP; bvalid && bready -> WR_IDLE.
REQ-016 Out-of-range write: no register changes, no reg_wr_stb, response per REQ-027/028.
REQ-017 Read FSM states: RD_IDLE, RD_RESP; arready high only in RD_IDLE.
REQ-018 AR handshake -> RD_RESP; rdata/rresp registered on that edge; rvalid high exactly while in RD_RESP.
REQ-019 rdata, rresp and bresp SHALL be held stable while valid and not ready.
REQ-020 rvalid && rready -> RD_IDLE; maximum read throughput one transfer per 2 cycles.
REQ-021 Read and write FSMs independent; read handshake on the write-commit edge returns the pre-write value.
REQ-022 bresp and rresp SHALL be 2'b00 (OKAY) for in-range accesses.

Reset
REQ-023 While axi4l_rst high: all registers 0; both FSMs to IDLE; awready, wready, arready, bvalid, rvalid, reg_wr_stb 0; rdata 0; bresp/rresp 2'b00.
REQ-024 Ready outputs SHALL rise on the first cycle after axi4l_rst deasserts.
REQ-025 Reset mid-transaction discards captured AW/W and pending responses; no register write completes.
REQ-026 Reset asserted on the would-be commit edge SHALL win over the write.

Configuration
REQ-027 With AXI4L_REGFILE_SLVERR_EN defined: out-of-range write returns bresp 2'b10; out-of-range read returns rresp 2'b10, rdata 0.
REQ-028 Without AXI4L_REGFILE_SLVERR_EN: out-of-range accesses return OKAY; writes are dropped and reads return rdata 0.

Verification
REQ-029 Reset, then AW 0x08 and W 0xDEADBEEF with wstrb 0xF in the same cycle -> bvalid next cycle, bresp 00, reg 2 = 0xDEADBEEF, reg_wr_stb[2] pulses once.
REQ-030 W 0x11223344 with wstrb 0x5 sent 3 cycles before AW 0x04, reg 1 preloaded 0xFFFFFFFF -> reg 1 = 0xFF22FF44; wready low until bready.
REQ-031 AR 0x08 with rready held low 5 cycles -> rvalid and rdata 0xDEADBEEF stable 5 cycles, arready low throughout.
REQ-032 Read of 0x40 with NUM_REGS=16 -> rdata 0; rresp 10 with the macro defined, 00 without.
REQ-033 Write to reg 3 with a simultaneous read of reg 3, old value 0x0 -> rdata 0x0; a following read returns the new value.
REQ-034 Assert axi4l_rst while in WR_HAVE_ADDR -> bvalid 0, registers 0, readies high on the first cycle after release.
